// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
// - FSM state encodings (IDLE, SCAN)
// - Result-vector encodings, ordered {AeqB, AgeqB, AltB}
package seq_magnitude_comparator_pkg;

  localparam logic IDLE = 1'b0;
  localparam logic SCAN = 1'b1;

  localparam logic [2:0] RES_EQ = 3'b110;
  localparam logic [2:0] RES_GT = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

endpackage

// File: rtl/seq_magnitude_comparator_bit_cell.sv
// cmp_bit_cell: combinational one-bit decision cell for the serial comparator.
// Ports:
//   a, b         : current operand bits under examination
//   is_sign_bit  : high when the examined bit is the operand MSB
//   signed_mode  : 1 = two's complement compare
//   differ       : a != b, this bit decides the compare
//   a_greater    : A > B given this bit decides
module cmp_bit_cell (
  input  logic a,
  input  logic b,
  input  logic is_sign_bit,
  input  logic signed_mode,
  output logic differ,
  output logic a_greater
);

  logic w_invert;

  // A set sign bit means a negative value, so the sense flips there.
  assign w_invert  = is_sign_bit & signed_mode;
  assign differ    = a ^ b;
  assign a_greater = differ & (a ^ w_invert);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: MSB-first bit-serial magnitude comparator with
// early termination at the first differing bit and a start/done handshake.
// Ports:
//   clk, reset (async, active-high)
//   start, signed_mode, A, B : request and operands, captured when idle
//   busy                     : compare in progress
//   done                     : one-cycle pulse when results update
//   AeqB, AgeqB, AltB        : registered results, held until next compare
module seq_magnitude_comparator
  import seq_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             AeqB,
  output logic             AgeqB,
  output logic             AltB
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  logic             r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_signed;
  logic [IDX_W-1:0] r_idx;
  logic             r_busy;
  logic             r_done;
  logic [2:0]       r_res;

  logic w_differ;
  logic w_a_greater;
  logic w_is_sign;

  // The index tracks which original bit sits at the shift-register MSB.
  assign w_is_sign = (r_idx == IDX_MSB);

  cmp_bit_cell u_bit_cell (
    .a           (r_a_sh[WIDTH-1]),
    .b           (r_b_sh[WIDTH-1]),
    .is_sign_bit (w_is_sign),
    .signed_mode (r_signed),
    .differ      (w_differ),
    .a_greater   (w_a_greater)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_signed <= 1'b0;
      r_idx    <= IDX_MSB;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_res    <= 3'b000;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh   <= A;
            r_b_sh   <= B;
            r_signed <= signed_mode;
            r_idx    <= IDX_MSB;
            r_busy   <= 1'b1;
            r_state  <= SCAN;
          end
        end
        SCAN: begin
          if (w_differ) begin
            r_res   <= w_a_greater ? RES_GT : RES_LT;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_idx != '0) begin
            r_a_sh <= r_a_sh << 1;
            r_b_sh <= r_b_sh << 1;
            r_idx  <= r_idx - IDX_W'(1);
          end else begin
            r_res   <= RES_EQ;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign {AeqB, AgeqB, AltB} = r_res;

endmodule
